// File: rtl/key_sel_debounce_pkg.sv
// Shared types for the push-button conditioning stage.
// Channel FSM encoding and default debounce timing.
package key_sel_debounce_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PCHK = 2'd1,
    S_HELD = 2'd2,
    S_RCHK = 2'd3
  } key_st_e;

  localparam int DEB_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF      = 16;
  localparam int SEL_W_DEF      = 2;
  localparam int N_KEYS_DEF     = 2;

endpackage

// File: rtl/key_sel_debounce_if.sv
// Key/select bundle between the board buttons and the mux select logic.
// master drives raw keys; slave returns conditioned levels, pulses and sel.
interface key_sel_debounce_if #(
  parameter int N_KEYS = 2,
  parameter int SEL_W  = 2
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [SEL_W-1:0]  sel;
  logic              sel_chg;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  sel,
    input  sel_chg
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output sel,
    output sel_chg
  );
endinterface

// File: rtl/key_sel_debounce_key.sv
// One button channel: 2-flop synchroniser, stability counter, FSM.
// level follows the debounced state; press pulses once per accepted press.
module key_sel_debounce_key
  import key_sel_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             p;
  key_st_e          st_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;

  // Released (high) is the safe reset value for an active-low button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign p = ~sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (p) begin
            st_q  <= S_PCHK;
            cnt_q <= ONE;
          end
        end
        S_PCHK: begin
          if (!p) begin
            st_q  <= S_IDLE;
            cnt_q <= '0;
          end else if (cnt_q == DEB) begin
            st_q    <= S_HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        S_HELD: begin
          if (!p) begin
            st_q  <= S_RCHK;
            cnt_q <= ONE;
          end
        end
        S_RCHK: begin
          if (p) begin
            st_q  <= S_HELD;
            cnt_q <= '0;
          end else if (cnt_q == DEB) begin
            st_q    <= S_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/key_sel_debounce.sv
// Button conditioning plus wrap-around mux select register.
// KEY0 steps sel up, KEY1 steps it down; simultaneous presses cancel.
module key_sel_debounce
  import key_sel_debounce_pkg::*;
#(
  parameter int N_KEYS     = N_KEYS_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int SEL_W      = SEL_W_DEF
) (
  input  logic clk,
  input  logic rst,
  key_sel_debounce_if.slave bus
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_sel_debounce_key #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_key (
      .clk     (clk),
      .rst     (rst),
      .key_n_i (bus.key_n[g]),
      .level_o (bus.key_level[g]),
      .press_o (bus.key_press[g])
    );
  end

  logic             inc;
  logic             dec;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic             sel_chg_q;
  logic             sel_chg_d;

  assign inc = bus.key_press[0] & ~bus.key_press[1];
  assign dec = bus.key_press[1] & ~bus.key_press[0];

  // Natural SEL_W-bit wrap gives the modulo step in both directions.
  always_comb begin
    sel_d     = sel_q;
    sel_chg_d = 1'b0;
    unique case (1'b1)
      inc: begin
        sel_d     = sel_q + SEL_W'(1);
        sel_chg_d = 1'b1;
      end
      dec: begin
        sel_d     = sel_q - SEL_W'(1);
        sel_chg_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      sel_chg_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.sel_chg = sel_chg_q;

endmodule

// File: tb/tb_key_sel_debounce.sv
// Directed bench for key_sel_debounce with a run-length debounce model.
// DEB_CYCLES=4, CNT_W=3; outputs compared every falling edge.
module tb_key_sel_debounce;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_sel_debounce_if #(.N_KEYS(2), .SEL_W(2)) ifc ();

  key_sel_debounce #(
    .N_KEYS     (2),
    .DEB_CYCLES (DEB),
    .CNT_W      (3),
    .SEL_W      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nmis = 0;
  int cyc  = 0;

  // Model: a key's level flips once the synchronised sample has
  // disagreed with it for DEB+1 consecutive clocks.
  logic [1:0] h1, h2;
  logic [1:0] mlvl, mpr;
  int         mrun [2];
  int         msel;
  logic       mchg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1   = 2'b11;
      h2   = 2'b11;
      mlvl = 2'b00;
      mpr  = 2'b00;
      mrun = '{0, 0};
      msel = 0;
      mchg = 1'b0;
    end else begin
      int up, dn;
      up   = (mpr == 2'b01) ? 1 : 0;
      dn   = (mpr == 2'b10) ? 1 : 0;
      mchg = (up + dn) != 0;
      msel = (msel + 4 + up - dn) % 4;
      mpr  = 2'b00;
      for (int k = 0; k < 2; k++) begin
        logic pk;
        pk = ~h2[k];
        if (pk != mlvl[k]) begin
          mrun[k]++;
          if (mrun[k] == DEB + 1) begin
            mlvl[k] = pk;
            mrun[k] = 0;
            if (pk) mpr[k] = 1'b1;
          end
        end else begin
          mrun[k] = 0;
        end
      end
      h2 = h1;
      h1 = ifc.key_n;
    end
  end

  always @(negedge clk) begin
    cyc++;
    ncmp++;
    if (ifc.key_level !== mlvl || ifc.key_press !== mpr ||
        ifc.sel !== 2'(msel) || ifc.sel_chg !== mchg) begin
      nmis++;
      $display("FAIL model cyc=%0d got lvl=%b prs=%b sel=%0d chg=%b want lvl=%b prs=%b sel=%0d chg=%b",
               cyc, ifc.key_level, ifc.key_press, ifc.sel, ifc.sel_chg,
               mlvl, mpr, msel, mchg);
    end
  end

  int pc0 = 0;
  int pc1 = 0;
  int pcc = 0;

  always @(negedge clk) begin
    if (ifc.key_press[0] === 1'b1) pc0++;
    if (ifc.key_press[1] === 1'b1) pc1++;
    if (ifc.sel_chg === 1'b1) pcc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_press(input int k, output int n);
    n = 21;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ifc.key_press[k] === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic tap(input int k);
    ifc.key_n[k] = 1'b0;
    cycles(10);
    ifc.key_n[k] = 1'b1;
    cycles(10);
  endtask

  int n, b0, b1, bc;
  int exp_sel [4] = '{1, 2, 3, 0};

  initial begin
    ifc.key_n = 2'b11;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    // 1: quiet after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_out",
          int'({ifc.key_level, ifc.key_press, ifc.sel, ifc.sel_chg}), 0);
    end
    cycles(1);

    // 2: four KEY0 presses step sel up and wrap
    for (int j = 0; j < 4; j++) begin
      ifc.key_n[0] = 1'b0;
      wait_press(0, n);
      chk("inc_latency", n, 8);
      @(negedge clk);
      chk("inc_sel", int'(ifc.sel), exp_sel[j]);
      chk("inc_chg", int'(ifc.sel_chg), 1);
      cycles(10);
      chk("inc_level", int'(ifc.key_level[0]), 1);
      ifc.key_n[0] = 1'b1;
      cycles(10);
      chk("rel_level", int'(ifc.key_level[0]), 0);
    end

    // 3: bounce rejected, then clean press
    b0 = pc0;
    ifc.key_n[0] = 1'b0;
    cycles(3);
    ifc.key_n[0] = 1'b1;
    cycles(1);
    ifc.key_n[0] = 1'b0;
    cycles(3);
    ifc.key_n[0] = 1'b1;
    cycles(10);
    chk("bounce_pulses", pc0 - b0, 0);
    chk("bounce_sel", int'(ifc.sel), 0);
    tap(0);
    chk("clean_pulses", pc0 - b0, 1);
    chk("clean_sel", int'(ifc.sel), 1);

    // 4: KEY1 steps down and wraps; long hold yields one pulse
    tap(1);
    chk("dec_sel", int'(ifc.sel), 0);
    b1 = pc1;
    ifc.key_n[1] = 1'b0;
    cycles(100);
    chk("hold_pulses", pc1 - b1, 1);
    chk("dec_wrap_sel", int'(ifc.sel), 3);
    ifc.key_n[1] = 1'b1;
    cycles(10);

    // 5: coincident presses cancel
    b0 = pc0;
    b1 = pc1;
    bc = pcc;
    ifc.key_n = 2'b00;
    cycles(10);
    chk("both_level", int'(ifc.key_level), 3);
    chk("both_sel", int'(ifc.sel), 3);
    chk("both_chg", pcc - bc, 0);
    chk("both_pulses", (pc0 - b0) + (pc1 - b1), 2);
    ifc.key_n = 2'b11;
    cycles(10);

    // 6: reset mid-qualification, key still held
    ifc.key_n[0] = 1'b0;
    cycles(4);
    b0 = pc0;
    rst = 1'b1;
    cycles(3);
    chk("rst_pulses", pc0 - b0, 0);
    chk("rst_sel", int'(ifc.sel), 0);
    rst = 1'b0;
    wait_press(0, n);
    chk("rst_latency", n, 8);
    @(negedge clk);
    chk("rst_after_sel", int'(ifc.sel), 1);
    ifc.key_n[0] = 1'b1;
    cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
